handshake_monitor: RTL and testbench
====================================

# handshake_monitor

Passive valid/ready bus monitor for the cosimulation bench. It taps a DUT stream interface and registers every accepted beat as a one-cycle pulse with its data. It counts beats and stall cycles and flags protocol violations as sticky error bits. Its `acc` and `err_pulse` outputs feed the level-detect event stages directly, so Python coroutines wake on clean, registered, glitch-free levels instead of raw DUT wires.

## Interface
Parameters:
- `DW`, 32, data width of the monitored bus
- `CNT_W`, 32, width of beat and stall counters
- `TIMEOUT`, 1024, stall cycles before timeout error; used only when the timeout feature is compiled in

Ports:
- `clk`  in  1  sole clock; all logic on posedge
- `rst`  in  1  reset, synchronous, active-high
- `valid`  in  1  monitored source valid
- `ready`  in  1  monitored sink ready
- `data`  in  DW  monitored payload
- `clr_err`  in  1  clears sticky `err` bits
- `acc`  out  1  one-cycle pulse, beat accepted in previous cycle
- `acc_data`  out  DW  payload of that beat; holds until next accept
- `beat_cnt`  out  CNT_W  accepted beats since reset
- `stall_cnt`  out  CNT_W  cycles of current stall (valid & !ready)
- `err`  out  3  sticky: [0] drop, [1] unstable, [2] timeout
- `err_pulse`  out  1  one-cycle pulse when any `err` bit newly sets

## Operation
- Accept: `valid && ready` sampled at posedge. Next cycle: `acc`=1, `acc_data`=`data`, `beat_cnt`+1.
- FSM states and transitions:
  - IDLE: on valid&!ready → PEND, capture `data` into hold register, `stall_cnt`=1.
  - PEND: valid&ready → IDLE (accept). valid&!ready → stay, `stall_cnt`+1. !valid → IDLE and set drop error.
  - TMO: entered from PEND when `stall_cnt` reaches TIMEOUT. Exits exactly like PEND.
- Unstable: in PEND/TMO with `valid` high and `data` != hold register → set err[1]. Checked on the accepting cycle too. The hold register is not updated, so the error keeps firing against the original value.
- Timeout: on PEND→TMO transition, set err[2]. It is set once per stall.
- `err_pulse` = 1 the cycle after any bit sets that was 0; no pulse if already set.
- `clr_err` zeroes `err` next cycle. If the same cycle also sets an error, the set wins.
- `beat_cnt` wraps 2^CNT_W-1 → 0. `stall_cnt` saturates at all-ones and returns to 0 on leaving PEND/TMO.
- Back-to-back accepts every cycle give `acc` held high, one count per cycle.

## Timing
- Reset values: `acc`=0, `acc_data`=0, `beat_cnt`=0, `stall_cnt`=0, `err`=0, `err_pulse`=0, FSM=IDLE, hold register=0.
- Latency: accept or error cycle N → outputs at N+1. No combinational input-to-output path.
- Inputs sampled while `rst`=1 are ignored. A beat on the reset cycle is not counted.
- Reset mid-stall: FSM→IDLE. The pending stall is forgotten, and a drop error is not raised on the following !valid.

## Configuration
- `HANDSHAKE_MONITOR_TIMEOUT_EN` defined:
  - TMO state, TIMEOUT comparison and err[2] are compiled in.
- Undefined:
  - FSM has IDLE/PEND only.
  - err[2] is tied 0.
  - `stall_cnt` still counts and saturates.

## Structure
- Shared package `nicotb_mon_pkg`:
  - FSM state enum (IDLE, PEND, TMO)
  - error-bit index constants ERR_DROP=0, ERR_UNSTABLE=1, ERR_TIMEOUT=2
- Sub-module `sat_counter` (param width; inc, clr, saturating), used for `stall_cnt`. `beat_cnt` is a plain wrapping counter inline.

## Test plan
- Reset, then accept every cycle for 4 cycles with data 1,2,3,4 → `acc` high 4 cycles starting 1 cycle later; `acc_data` 1..4; `beat_cnt`=4; `err`=0.
- valid=1, data=0xA5, ready=0 for 3 cycles, then ready=1 → `stall_cnt` 1,2,3 then 0; one accept with `acc_data`=0xA5; no error.
- valid&!ready one cycle, then valid=0 → err[0]=1 and `err_pulse` one cycle; `clr_err` → `err`=0 next cycle.
- Stall with data changing 0x10→0x11 → err[1] set, single `err_pulse`; pulsing `clr_err` while the data stays changed → err[1] re-sets next cycle.
- TIMEOUT=8, macro defined, stall 10 cycles → err[2] set at stall cycle 8; same test with macro undefined → err[2]=0, `stall_cnt`=10.
- CNT_W=4, 17 accepts → `beat_cnt`=1; `rst` asserted mid-stall then valid=0 → no drop error, all outputs at reset values.

Source files
------------

// File: rtl/nicotb_mon_pkg.sv
// nicotb_mon_pkg: shared FSM state and error-bit indices for the handshake monitor
package nicotb_mon_pkg;
  typedef enum logic [1:0] {IDLE, PEND, TMO} state_t;
  localparam int ERR_DROP = 0;
  localparam int ERR_UNSTABLE = 1;
  localparam int ERR_TIMEOUT = 2;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; clr has priority over inc
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/handshake_monitor.sv
// handshake_monitor: passive valid/ready tap with registered accept pulses and sticky errors; timeout via HANDSHAKE_MONITOR_TIMEOUT_EN
module handshake_monitor
  import nicotb_mon_pkg::*;
#(
  parameter int DW = 32,
  parameter int CNT_W = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             ready,
  input  logic [DW-1:0]    data,
  input  logic             clr_err,
  output logic             acc,
  output logic [DW-1:0]    acc_data,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [2:0]       err,
  output logic             err_pulse
);
  state_t state, state_nx;
  logic [DW-1:0] hold;
  logic [2:0] set;
  logic stall, in_pend;
  assign stall = valid & ~ready;
  assign in_pend = state != IDLE;
  always_comb begin
    set = '0;
    set[ERR_DROP] = in_pend & ~valid;
    set[ERR_UNSTABLE] = in_pend & valid & (data != hold);
`ifdef HANDSHAKE_MONITOR_TIMEOUT_EN
    // stall_cnt becomes TIMEOUT on this edge, so the error lands with it
    set[ERR_TIMEOUT] = (state == PEND) & stall & (stall_cnt >= CNT_W'(TIMEOUT - 1));
    state_nx = !stall ? IDLE : (state == IDLE) ? PEND : set[ERR_TIMEOUT] ? TMO : state;
`else
    state_nx = stall ? PEND : IDLE;
`endif
  end
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk),
    .rst(rst),
    .inc(stall),
    .clr(~stall),
    .q  (stall_cnt)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      hold      <= '0;
      acc       <= 1'b0;
      acc_data  <= '0;
      beat_cnt  <= '0;
      err       <= '0;
      err_pulse <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && stall) hold <= data;
      acc <= valid & ready;
      if (valid && ready) begin
        acc_data <= data;
        beat_cnt <= beat_cnt + 1'b1;
      end
      err       <= (clr_err ? 3'b000 : err) | set;
      err_pulse <= |(set & ~err);
    end
endmodule

// File: tb/tb_handshake_monitor.sv
// tb_handshake_monitor: directed vector table, corner sequences and randomized model check
module tb_handshake_monitor;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, ready = 1'b0, clr_err = 1'b0;
  logic [7:0] data = '0;
  logic acc, err_pulse;
  logic [7:0] acc_data;
  logic [3:0] beat_cnt, stall_cnt;
  logic [2:0] err;
`ifdef HANDSHAKE_MONITOR_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  handshake_monitor #(.DW(8), .CNT_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .data(data), .clr_err(clr_err),
    .acc(acc), .acc_data(acc_data), .beat_cnt(beat_cnt), .stall_cnt(stall_cnt),
    .err(err), .err_pulse(err_pulse)
  );
  always #5 clk = ~clk;
  int passed = 0, total = 0;
  typedef struct {
    logic v, r, c, rs;
    logic [7:0] d;
    logic [20:0] exp;
  } vec_t;
  vec_t tbl[$];
  function automatic logic [20:0] pk(input logic a, input logic [7:0] ad, input logic [3:0] bc, sc,
                                     input logic [2:0] er, input logic ep);
    return {a, ad, bc, sc, er, ep};
  endfunction
  task automatic add(input logic v, r, input logic [7:0] d, input logic c, rs, input logic [20:0] e);
    vec_t x;
    x.v = v; x.r = r; x.d = d; x.c = c; x.rs = rs; x.exp = e;
    tbl.push_back(x);
  endtask
  // reference model: tracks whether the previous cycle was a stall and what was offered then
  bit m_pend, m_tmo, m_acc, m_pulse;
  logic [7:0] m_hold, m_ad;
  int m_stall, m_beats;
  logic [2:0] m_err;
  task automatic step(input logic v, r, input logic [7:0] d, input logic c, rs);
    bit st;
    int nst;
    logic [2:0] s;
    valid = v; ready = r; data = d; clr_err = c; rst = rs;
    @(posedge clk);
    if (rs) begin
      m_pend = 0; m_tmo = 0; m_hold = '0; m_stall = 0; m_beats = 0;
      m_err = '0; m_acc = 0; m_ad = '0; m_pulse = 0;
    end else begin
      st = v && !r;
      nst = st ? ((m_stall + 1 > 15) ? 15 : m_stall + 1) : 0;
      s = '0;
      if (m_pend && !v) s[0] = 1'b1;
      if (m_pend && v && d != m_hold) s[1] = 1'b1;
      if (TEN && m_pend && !m_tmo && st && nst >= 8) begin
        s[2] = 1'b1;
        m_tmo = 1;
      end
      if (!m_pend && st) m_hold = d;
      if (!st) m_tmo = 0;
      m_pend = st;
      m_stall = nst;
      m_acc = v && r;
      if (v && r) begin
        m_ad = d;
        m_beats = (m_beats + 1) % 16;
      end
      m_pulse = |(s & ~m_err);
      m_err = (c ? 3'b000 : m_err) | s;
    end
    #1;
  endtask
  task automatic chk(input string tag, input int idx, input logic [20:0] e);
    logic [20:0] g;
    g = {acc, acc_data, beat_cnt, stall_cnt, err, err_pulse};
    total++;
    if (g === e) passed++;
    else $display("FAIL %s[%0d] got acc/data/beat/stall/err/pulse=%h expected %h", tag, idx, g, e);
  endtask
  initial begin
    // reset
    add(0, 0, 8'h00, 0, 1, pk(0, 8'h00, 0, 0, 3'b000, 0));
    add(0, 0, 8'h00, 0, 1, pk(0, 8'h00, 0, 0, 3'b000, 0));
    // back-to-back accepts 1..4
    add(1, 1, 8'h01, 0, 0, pk(1, 8'h01, 1, 0, 3'b000, 0));
    add(1, 1, 8'h02, 0, 0, pk(1, 8'h02, 2, 0, 3'b000, 0));
    add(1, 1, 8'h03, 0, 0, pk(1, 8'h03, 3, 0, 3'b000, 0));
    add(1, 1, 8'h04, 0, 0, pk(1, 8'h04, 4, 0, 3'b000, 0));
    add(0, 0, 8'h00, 0, 0, pk(0, 8'h04, 4, 0, 3'b000, 0));
    // 3-cycle stall then accept of 0xA5
    add(1, 0, 8'hA5, 0, 0, pk(0, 8'h04, 4, 1, 3'b000, 0));
    add(1, 0, 8'hA5, 0, 0, pk(0, 8'h04, 4, 2, 3'b000, 0));
    add(1, 0, 8'hA5, 0, 0, pk(0, 8'h04, 4, 3, 3'b000, 0));
    add(1, 1, 8'hA5, 0, 0, pk(1, 8'hA5, 5, 0, 3'b000, 0));
    add(0, 0, 8'h00, 0, 0, pk(0, 8'hA5, 5, 0, 3'b000, 0));
    // drop, then clear
    add(1, 0, 8'h07, 0, 0, pk(0, 8'hA5, 5, 1, 3'b000, 0));
    add(0, 0, 8'h07, 0, 0, pk(0, 8'hA5, 5, 0, 3'b001, 1));
    add(0, 0, 8'h00, 0, 0, pk(0, 8'hA5, 5, 0, 3'b001, 0));
    add(0, 0, 8'h00, 1, 0, pk(0, 8'hA5, 5, 0, 3'b000, 0));
    add(0, 0, 8'h00, 0, 0, pk(0, 8'hA5, 5, 0, 3'b000, 0));
    // unstable data; clear loses to a concurrent set
    add(1, 0, 8'h10, 0, 0, pk(0, 8'hA5, 5, 1, 3'b000, 0));
    add(1, 0, 8'h11, 0, 0, pk(0, 8'hA5, 5, 2, 3'b010, 1));
    add(1, 0, 8'h11, 1, 0, pk(0, 8'hA5, 5, 3, 3'b010, 0));
    add(1, 0, 8'h11, 0, 0, pk(0, 8'hA5, 5, 4, 3'b010, 0));
    add(1, 1, 8'h11, 0, 0, pk(1, 8'h11, 6, 0, 3'b010, 0));
    add(0, 0, 8'h00, 1, 0, pk(0, 8'h11, 6, 0, 3'b000, 0));
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].c, tbl[i].rs);
      chk("table", i, tbl[i].exp);
    end
    // long stall: timeout at stall cycle 8 (when enabled), stall_cnt saturates at 15
    for (int k = 1; k <= 17; k++) begin
      step(1, 0, 8'h33, 0, 0);
      chk("stall", k, pk(0, 8'h11, 6, 4'((k > 15) ? 15 : k), (TEN && k >= 8) ? 3'b100 : 3'b000,
                        TEN && k == 8));
    end
    step(1, 1, 8'h33, 0, 0);
    chk("stall_acc", 0, pk(1, 8'h33, 7, 0, TEN ? 3'b100 : 3'b000, 0));
    step(0, 0, 8'h00, 1, 0);
    chk("stall_clr", 0, pk(0, 8'h33, 7, 0, 3'b000, 0));
    // beat counter wrap
    step(0, 0, 8'h00, 0, 1);
    chk("wrap_rst", 0, pk(0, 8'h00, 0, 0, 3'b000, 0));
    for (int k = 1; k <= 17; k++) begin
      step(1, 1, 8'(k), 0, 0);
      chk("wrap", k, pk(1, 8'(k), 4'(k % 16), 0, 3'b000, 0));
    end
    // reset in the middle of a stall forgets it
    step(1, 0, 8'h05, 0, 0);
    chk("mid_stall", 1, pk(0, 8'h11, 1, 1, 3'b000, 0));
    step(1, 0, 8'h05, 0, 0);
    chk("mid_stall", 2, pk(0, 8'h11, 1, 2, 3'b000, 0));
    step(1, 0, 8'h05, 0, 1);
    chk("mid_rst", 0, pk(0, 8'h00, 0, 0, 3'b000, 0));
    step(0, 0, 8'h00, 0, 0);
    chk("no_drop", 0, pk(0, 8'h00, 0, 0, 3'b000, 0));
    // randomized traffic against the model
    begin
      logic [7:0] d;
      d = 8'h10;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 9) == 0) d = 8'($urandom_range(8'h10, 8'h13));
        step($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, d,
             $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
        chk("rand", i, pk(m_acc, m_ad, 4'(m_beats), 4'(m_stall), m_err, m_pulse));
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
